// File: rtl/rob_commit_nway_pkg.sv
// Shared types for the reorder buffer and in-order commit unit of the out-of-order MIPS core.
// Writeback indices are carried at a fixed width so the types stay independent of ROB_DEPTH.
package rob_commit_nway_pkg;

   localparam int ROB_WB_IDX_W = 8;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_RI   = 5'h0a;

   typedef enum logic [1:0] {
      Inst_Invalid  = 2'd0,
      Inst_Issued   = 2'd1,
      Inst_Complete = 2'd2
   } rob_state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] exccode;
   } exception_t;

   typedef struct packed {
      logic        valid;
      logic        miss_predict;
      logic        taken;
      logic [31:0] target;
   } verify_result_t;

   typedef struct packed {
      logic       we;
      logic [4:0] dest;
      logic [5:0] phy_dest;
      logic [5:0] old_dest;
   } commit_to_rat_bus_t;

   typedef struct packed {
      logic               is_branch;
      logic               is_store;
      logic               is_eret;
      logic               is_priv;
      commit_to_rat_bus_t rat;
   } rob_entry_t;

   typedef struct packed {
      logic [ROB_WB_IDX_W-1:0] idx;
      exception_t              ex;
      verify_result_t          vr;
   } rob_wb_t;

   typedef struct packed {
      logic miss_predict;
      logic exception;
      logic eret;
      logic privileged_inst;
   } flush_src_t;

endpackage

// File: rtl/rob_commit_select.sv
// Lane-qualification chain over the COMMIT_WIDTH oldest ROB entries: decides which lanes
// retire this cycle and whether the retiring group (or a faulting head) requests a flush.
module rob_commit_select
   import rob_commit_nway_pkg::*;
#(
   parameter int COMMIT_WIDTH = 2
)(
   input  logic                    enable,
   input  logic [COMMIT_WIDTH-1:0] complete,
   input  logic [COMMIT_WIDTH-1:0] faulted,
   input  logic [COMMIT_WIDTH-1:0] is_branch,
   input  logic [COMMIT_WIDTH-1:0] is_eret,
   input  logic [COMMIT_WIDTH-1:0] is_priv,
   input  verify_result_t          vr [COMMIT_WIDTH],
   output logic [COMMIT_WIDTH-1:0] cm_valid,
   output logic                    flush_req,
   output flush_src_t              flush_cause,
   output verify_result_t          br_verify
);

   always_comb begin
      logic stop;
      int   nxt;
      cm_valid    = '0;
      flush_req   = 1'b0;
      flush_cause = '0;
      br_verify   = '0;
      stop        = !enable;
      nxt         = 0;

      // A faulting head blocks everything and wins over any other flush cause.
      if (enable && complete[0] && faulted[0]) begin
         flush_req             = 1'b1;
         flush_cause.exception = 1'b1;
         stop                  = 1'b1;
      end

      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         nxt = (k + 1 < COMMIT_WIDTH) ? k + 1 : k;
         if (!stop) begin
            if (!complete[k] || faulted[k]) begin
               stop = 1'b1;
            end else if (is_eret[k] || is_priv[k]) begin
               if (k == 0) begin
                  cm_valid[k]                 = 1'b1;
                  flush_req                   = 1'b1;
                  flush_cause.eret            = is_eret[k];
                  flush_cause.privileged_inst = is_priv[k] && !is_eret[k];
               end
               stop = 1'b1;
            end else if (is_branch[k]) begin
               // The branch waits for its delay slot; a faulting slot lets the branch go alone.
               if (k + 1 < COMMIT_WIDTH && complete[nxt]) begin
                  cm_valid[k] = 1'b1;
                  br_verify   = vr[k];
                  if (!faulted[nxt]) begin
                     cm_valid[nxt] = 1'b1;
                     if (vr[k].miss_predict) begin
                        flush_req                = 1'b1;
                        flush_cause.miss_predict = 1'b1;
                     end
                  end
               end
               stop = 1'b1;
            end else begin
               cm_valid[k] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rob_commit_nway.sv
// Parametrised reorder buffer with wrap-bit pointers, N-wide dispatch and commit,
// multi-port writeback and a registered one-cycle flush pulse with its cause.
module rob_commit_nway
   import rob_commit_nway_pkg::*;
#(
   parameter  int ROB_DEPTH      = 32,
   parameter  int DISPATCH_WIDTH = 2,
   parameter  int COMMIT_WIDTH   = 2,
   parameter  int WB_PORTS       = 3,
   localparam int IDX_W          = $clog2(ROB_DEPTH)
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DISPATCH_WIDTH-1:0] disp_valid,
   input  rob_entry_t                disp_entry [DISPATCH_WIDTH],
   output logic                      disp_allowin,
   output logic [IDX_W-1:0]          rob_tail,
   output logic                      rob_empty,
   input  logic [WB_PORTS-1:0]       wb_valid,
   input  rob_wb_t                   wb_info [WB_PORTS],
   output logic [COMMIT_WIDTH-1:0]   cm_valid,
   output commit_to_rat_bus_t        cm_rat [COMMIT_WIDTH],
   output logic [COMMIT_WIDTH-1:0]   cm_store,
   output verify_result_t            bpu_verify,
   output logic                      flush,
   output flush_src_t                flush_cause,
   output exception_t                exception
);

   localparam int PTR_W = IDX_W + 1;

   rob_state_t     slot_state [ROB_DEPTH];
   rob_entry_t     slot_entry [ROB_DEPTH];
   exception_t     slot_ex    [ROB_DEPTH];
   verify_result_t slot_vr    [ROB_DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] count;
   logic [PTR_W-1:0] free_slots;
   logic [PTR_W-1:0] disp_num;
   logic [PTR_W-1:0] cm_num;
   logic             disp_fire;

   rob_entry_t                head_entry [COMMIT_WIDTH];
   exception_t                head_ex    [COMMIT_WIDTH];
   verify_result_t            head_vr    [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0]   head_complete;
   logic [COMMIT_WIDTH-1:0]   head_faulted;
   logic [COMMIT_WIDTH-1:0]   head_branch;
   logic [COMMIT_WIDTH-1:0]   head_eret;
   logic [COMMIT_WIDTH-1:0]   head_priv;
   logic                      sel_flush;
   flush_src_t                sel_cause;
   verify_result_t            sel_verify;

   logic [WB_PORTS-1:0] wb_hit;
   logic [IDX_W-1:0]    wb_slot [WB_PORTS];

   assign count        = tail - head;
   assign free_slots   = PTR_W'(ROB_DEPTH) - count;
   assign rob_empty    = (count == '0);
   assign rob_tail     = tail[IDX_W-1:0];
   // Occupancy before this cycle's commits, so a full group always fits.
   assign disp_allowin = !flush && (free_slots >= PTR_W'(DISPATCH_WIDTH));
   assign disp_fire    = disp_valid[0] && disp_allowin;

   always_comb begin
      disp_num = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) disp_num += PTR_W'(disp_valid[k]);
      cm_num = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) cm_num += PTR_W'(cm_valid[k]);
   end

   for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_head
      logic [IDX_W-1:0] idx;
      assign idx              = head[IDX_W-1:0] + IDX_W'(k);
      assign head_entry[k]    = slot_entry[idx];
      assign head_ex[k]       = slot_ex[idx];
      assign head_vr[k]       = slot_vr[idx];
      assign head_complete[k] = (slot_state[idx] == Inst_Complete);
      assign head_faulted[k]  = slot_ex[idx].valid;
      assign head_branch[k]   = slot_entry[idx].is_branch;
      assign head_eret[k]     = slot_entry[idx].is_eret;
      assign head_priv[k]     = slot_entry[idx].is_priv;
      assign cm_store[k]      = cm_valid[k] && head_entry[k].is_store;
      assign cm_rat[k]        = '{we:       head_entry[k].rat.we && cm_valid[k],
                                  dest:     head_entry[k].rat.dest,
                                  phy_dest: head_entry[k].rat.phy_dest,
                                  old_dest: head_entry[k].rat.old_dest};
   end

   for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
      assign wb_slot[p] = wb_info[p].idx[IDX_W-1:0];
      assign wb_hit[p]  = wb_valid[p] && !flush
                       && ({1'b0, wb_info[p].idx} < (ROB_WB_IDX_W + 1)'(ROB_DEPTH))
                       && (slot_state[wb_slot[p]] != Inst_Invalid);
   end

   rob_commit_select #(
      .COMMIT_WIDTH (COMMIT_WIDTH)
   ) u_select (
      .enable      (!flush),
      .complete    (head_complete),
      .faulted     (head_faulted),
      .is_branch   (head_branch),
      .is_eret     (head_eret),
      .is_priv     (head_priv),
      .vr          (head_vr),
      .cm_valid    (cm_valid),
      .flush_req   (sel_flush),
      .flush_cause (sel_cause),
      .br_verify   (sel_verify)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         head        <= '0;
         tail        <= '0;
         flush       <= 1'b0;
         flush_cause <= '0;
         exception   <= '0;
         bpu_verify  <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) slot_state[i] <= Inst_Invalid;
      end else if (sel_flush) begin
         head        <= '0;
         tail        <= '0;
         flush       <= 1'b1;
         flush_cause <= sel_cause;
         exception   <= sel_cause.exception ? head_ex[0] : '0;
         bpu_verify  <= sel_cause.exception ? '0 : sel_verify;
         for (int i = 0; i < ROB_DEPTH; i++) slot_state[i] <= Inst_Invalid;
      end else begin
         flush       <= 1'b0;
         flush_cause <= '0;
         exception   <= '0;
         bpu_verify  <= sel_verify;
         head        <= head + cm_num;
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (cm_valid[k]) slot_state[head[IDX_W-1:0] + IDX_W'(k)] <= Inst_Invalid;
         end
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_hit[p]) slot_state[wb_slot[p]] <= Inst_Complete;
         end
         if (disp_fire) begin
            tail <= tail + disp_num;
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
               if (disp_valid[k]) slot_state[tail[IDX_W-1:0] + IDX_W'(k)] <= Inst_Issued;
            end
         end
      end
   end

   // Payload storage carries no reset; slot_state alone says what is meaningful.
   always_ff @(posedge clk) begin
      if (disp_fire) begin
         for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (disp_valid[k]) begin
               slot_entry[tail[IDX_W-1:0] + IDX_W'(k)] <= disp_entry[k];
               slot_ex[tail[IDX_W-1:0] + IDX_W'(k)]    <= '0;
               slot_vr[tail[IDX_W-1:0] + IDX_W'(k)]    <= '0;
            end
         end
      end
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_hit[p]) begin
            slot_ex[wb_slot[p]] <= wb_info[p].ex;
            slot_vr[wb_slot[p]] <= wb_info[p].vr;
         end
      end
   end

endmodule

// File: tb/tb_rob_commit_nway.sv
// Directed bench for rob_commit_nway: fill/drain with wrap, branch/delay-slot pairing,
// mispredict and exception flushes. Inputs change and outputs are sampled around negedge.
module tb_rob_commit_nway;
   import rob_commit_nway_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         disp_valid;
   rob_entry_t         disp_entry [2];
   logic               disp_allowin;
   logic [4:0]         rob_tail;
   logic               rob_empty;
   logic [2:0]         wb_valid;
   rob_wb_t            wb_info [3];
   logic [1:0]         cm_valid;
   commit_to_rat_bus_t cm_rat [2];
   logic [1:0]         cm_store;
   verify_result_t     bpu_verify;
   logic               flush;
   flush_src_t         flush_cause;
   exception_t         exception;

   int             checkCount = 0;
   int             errorCount = 0;
   logic [5:0]     modelHead;
   logic [5:0]     modelTail;
   logic [5:0]     br;
   logic [5:0]     ex0;
   verify_result_t vrMiss;
   verify_result_t vrOk;
   exception_t     exAdEL;
   exception_t     exRI;

   rob_commit_nway dut (
      .clk          (clk),
      .reset        (reset),
      .disp_valid   (disp_valid),
      .disp_entry   (disp_entry),
      .disp_allowin (disp_allowin),
      .rob_tail     (rob_tail),
      .rob_empty    (rob_empty),
      .wb_valid     (wb_valid),
      .wb_info      (wb_info),
      .cm_valid     (cm_valid),
      .cm_rat       (cm_rat),
      .cm_store     (cm_store),
      .bpu_verify   (bpu_verify),
      .flush        (flush),
      .flush_cause  (flush_cause),
      .exception    (exception)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int p = 0; p < 3; p++) begin
         for (int q = p + 1; q < 3; q++) begin
            assert (!(wb_valid[p] && wb_valid[q] && wb_info[p].idx == wb_info[q].idx))
               else $error("[TB] writeback ports %0d and %0d alias idx %0d", p, q, wb_info[p].idx);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic rob_entry_t mkEntry(input logic isBr, input logic [5:0] slot);
      rob_entry_t e;
      e              = '0;
      e.is_branch    = isBr;
      e.is_store     = slot[0] & ~isBr;
      e.rat.we       = 1'b1;
      e.rat.dest     = slot[4:0];
      e.rat.phy_dest = slot;
      e.rat.old_dest = ~slot;
      return e;
   endfunction

   task automatic clearInputs();
      disp_valid = '0;
      wb_valid   = '0;
   endtask

   task automatic applyStimulus(input int lanes, input logic br0);
      disp_valid = '0;
      for (int k = 0; k < 2; k++) begin
         disp_entry[k] = mkEntry((k == 0) && br0, modelTail + 6'(k));
         if (k < lanes) disp_valid[k] = 1'b1;
      end
   endtask

   task automatic setWb(input int p, input logic [5:0] slot, input exception_t ex, input verify_result_t vr);
      wb_valid[p]    = 1'b1;
      wb_info[p].idx = 8'(slot[4:0]);
      wb_info[p].ex  = ex;
      wb_info[p].vr  = vr;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   // Dispatch n plain ops, complete them youngest-first, then drain two per cycle.
   task automatic fillDrain(input int n);
      int         placed;
      int         lanes;
      int         rem;
      logic [5:0] h1;
      logic [1:0] expStore;
      placed = 0;
      while (placed < n) begin
         lanes = (n - placed >= 2) ? 2 : 1;
         clearInputs();
         applyStimulus(lanes, 1'b0);
         #1;
         checkOutput("fill_allowin", 64'(disp_allowin), 64'((32 - placed) >= 2));
         checkOutput("fill_tail", 64'(rob_tail), 64'(modelTail[4:0]));
         nextCycle();
         modelTail += 6'(lanes);
         placed    += lanes;
      end
      clearInputs();
      #1;
      checkOutput("full_allowin", 64'(disp_allowin), 64'(0));
      checkOutput("full_empty", 64'(rob_empty), 64'(0));
      checkOutput("full_tail", 64'(rob_tail), 64'(modelTail[4:0]));
      for (int i = n - 1; i >= 0; i--) begin
         clearInputs();
         setWb(0, modelHead + 6'(i), '0, '0);
         #1;
         checkOutput("rev_wb_noretire", 64'(cm_valid), 64'(0));
         nextCycle();
      end
      rem = n;
      while (rem > 0) begin
         lanes    = (rem >= 2) ? 2 : 1;
         h1       = modelHead + 6'd1;
         expStore = {(lanes == 2) && h1[0], modelHead[0]};
         clearInputs();
         #1;
         checkOutput("drain_cm", 64'(cm_valid), (lanes == 2) ? 64'(2'b11) : 64'(2'b01));
         checkOutput("drain_dest0", 64'(cm_rat[0].dest), 64'(modelHead[4:0]));
         checkOutput("drain_store", 64'(cm_store), 64'(expStore));
         nextCycle();
         modelHead += 6'(lanes);
         rem       -= lanes;
      end
      clearInputs();
      #1;
      checkOutput("drained_empty", 64'(rob_empty), 64'(1));
      checkOutput("drained_allowin", 64'(disp_allowin), 64'(1));
   endtask

   initial begin
      vrMiss = '{valid: 1'b1, miss_predict: 1'b1, taken: 1'b1, target: 32'h0000_1234};
      vrOk   = '{valid: 1'b1, miss_predict: 1'b0, taken: 1'b0, target: 32'h0000_0040};
      exAdEL = '{valid: 1'b1, exccode: EXC_ADEL};
      exRI   = '{valid: 1'b1, exccode: EXC_RI};
      for (int p = 0; p < 3; p++) wb_info[p] = '0;
      modelHead = '0;
      modelTail = '0;
      reset     = 1'b1;
      clearInputs();
      applyStimulus(2, 1'b0);
      nextCycle();
      nextCycle();
      #1;
      checkOutput("rst_empty", 64'(rob_empty), 64'(1));
      checkOutput("rst_allowin", 64'(disp_allowin), 64'(1));
      checkOutput("rst_cm", 64'(cm_valid), 64'(0));
      checkOutput("rst_flush", 64'(flush), 64'(0));
      checkOutput("rst_cause", 64'(flush_cause), 64'(0));
      checkOutput("rst_bpu", 64'(bpu_verify), 64'(0));
      checkOutput("rst_tail", 64'(rob_tail), 64'(0));
      reset = 1'b0;
      clearInputs();
      nextCycle();

      $display("[TB] fill/drain 32 and wrap rounds");
      fillDrain(32);
      for (int r = 0; r < 3; r++) fillDrain(31);

      $display("[TB] mispredicted branch with complete delay slot");
      clearInputs();
      applyStimulus(2, 1'b1);
      nextCycle();
      br = modelTail;
      modelTail += 6'd2;
      clearInputs();
      setWb(0, br, '0, vrMiss);
      setWb(1, br + 6'd1, '0, '0);
      #1;
      checkOutput("mp_wb_same_cycle", 64'(cm_valid), 64'(0));
      nextCycle();
      clearInputs();
      #1;
      checkOutput("mp_pair_cm", 64'(cm_valid), 64'(2'b11));
      checkOutput("mp_no_flush_yet", 64'(flush), 64'(0));
      nextCycle();
      clearInputs();
      applyStimulus(2, 1'b0);
      setWb(0, br, '0, '0);
      #1;
      checkOutput("mp_flush", 64'(flush), 64'(1));
      checkOutput("mp_cause", 64'(flush_cause), 64'(4'b1000));
      checkOutput("mp_bpu", 64'(bpu_verify), 64'(vrMiss));
      checkOutput("mp_flush_cm", 64'(cm_valid), 64'(0));
      checkOutput("mp_flush_allowin", 64'(disp_allowin), 64'(0));
      checkOutput("mp_tail", 64'(rob_tail), 64'(0));
      checkOutput("mp_empty", 64'(rob_empty), 64'(1));
      nextCycle();
      modelHead = '0;
      modelTail = '0;
      clearInputs();
      #1;
      checkOutput("mp_flush_drop", 64'(flush), 64'(0));
      checkOutput("mp_post_tail", 64'(rob_tail), 64'(0));
      checkOutput("mp_post_empty", 64'(rob_empty), 64'(1));
      checkOutput("mp_post_bpu", 64'(bpu_verify), 64'(0));

      $display("[TB] branch waits for delay slot");
      clearInputs();
      applyStimulus(2, 1'b1);
      nextCycle();
      br = modelTail;
      modelTail += 6'd2;
      clearInputs();
      setWb(0, br, '0, vrOk);
      #1;
      checkOutput("ds_br_wb", 64'(cm_valid), 64'(0));
      nextCycle();
      for (int i = 0; i < 5; i++) begin
         clearInputs();
         #1;
         checkOutput("ds_wait_cm", 64'(cm_valid), 64'(0));
         nextCycle();
      end
      clearInputs();
      setWb(0, br + 6'd1, '0, '0);
      #1;
      checkOutput("ds_wb_same_cycle", 64'(cm_valid), 64'(0));
      nextCycle();
      clearInputs();
      #1;
      checkOutput("ds_pair_cm", 64'(cm_valid), 64'(2'b11));
      checkOutput("ds_pair_dest1", 64'(cm_rat[1].dest), 64'(br[4:0] + 5'd1));
      nextCycle();
      modelHead += 6'd2;
      clearInputs();
      #1;
      checkOutput("ds_no_flush", 64'(flush), 64'(0));
      checkOutput("ds_bpu", 64'(bpu_verify), 64'(vrOk));
      checkOutput("ds_empty", 64'(rob_empty), 64'(1));

      $display("[TB] exception at head");
      clearInputs();
      applyStimulus(2, 1'b1);
      nextCycle();
      br = modelTail;
      modelTail += 6'd2;
      clearInputs();
      applyStimulus(2, 1'b0);
      nextCycle();
      ex0 = modelTail;
      modelTail += 6'd2;
      clearInputs();
      setWb(0, br, '0, vrOk);
      setWb(1, br + 6'd1, '0, '0);
      setWb(2, ex0, exAdEL, '0);
      nextCycle();
      clearInputs();
      #1;
      checkOutput("exc_pre_pair", 64'(cm_valid), 64'(2'b11));
      nextCycle();
      modelHead += 6'd2;
      clearInputs();
      setWb(0, ex0 + 6'd1, '0, '0);
      #1;
      checkOutput("exc_no_retire", 64'(cm_valid), 64'(0));
      checkOutput("exc_pre_bpu", 64'(bpu_verify), 64'(vrOk));
      checkOutput("exc_pre_flush", 64'(flush), 64'(0));
      nextCycle();
      clearInputs();
      #1;
      checkOutput("exc_flush", 64'(flush), 64'(1));
      checkOutput("exc_cause", 64'(flush_cause), 64'(4'b0100));
      checkOutput("exc_value", 64'(exception), 64'(exAdEL));
      checkOutput("exc_bpu_zero", 64'(bpu_verify), 64'(0));
      checkOutput("exc_tail", 64'(rob_tail), 64'(0));
      nextCycle();
      modelHead = '0;
      modelTail = '0;
      clearInputs();
      #1;
      checkOutput("exc_flush_drop", 64'(flush), 64'(0));
      checkOutput("exc_clear", 64'(exception), 64'(0));

      $display("[TB] delay-slot exception after mispredicted branch");
      clearInputs();
      applyStimulus(2, 1'b1);
      nextCycle();
      br = modelTail;
      modelTail += 6'd2;
      clearInputs();
      setWb(0, br, '0, vrMiss);
      setWb(1, br + 6'd1, exRI, '0);
      nextCycle();
      clearInputs();
      #1;
      checkOutput("dsx_branch_alone", 64'(cm_valid), 64'(2'b01));
      nextCycle();
      modelHead += 6'd1;
      clearInputs();
      #1;
      checkOutput("dsx_no_mp_flush", 64'(flush), 64'(0));
      checkOutput("dsx_bpu", 64'(bpu_verify), 64'(vrMiss));
      checkOutput("dsx_head_blocked", 64'(cm_valid), 64'(0));
      nextCycle();
      clearInputs();
      #1;
      checkOutput("dsx_flush", 64'(flush), 64'(1));
      checkOutput("dsx_cause", 64'(flush_cause), 64'(4'b0100));
      checkOutput("dsx_exc", 64'(exception), 64'(exRI));
      nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
